// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one synchronous single-port SRAM between instruction fetch and data requesters.
// One access in flight at a time; data has priority, bounded by a streak limit to protect fetch.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SRAM_LAT   = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_we,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_done,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int CNT_W    = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t              state;
    owner_t              owner;
    logic [STREAK_W-1:0] streak;
    logic [CNT_W-1:0]    wait_cnt;
    logic                grant_data;

    // Data wins unless fetch is waiting and data has used up its streak.
    always_comb begin
        grant_data = data_req && !(inst_req && (streak == STREAK_W'(MAX_STREAK)));
    end

    // The sram_we/addr/wdata registers double as the latched command of the granted requester.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            streak     <= '0;
            wait_cnt   <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            inst_done  <= 1'b0;
            inst_rdata <= '0;
            data_done  <= 1'b0;
            data_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only in the cycle that needs them;
            // all state uses non-blocking assignments so every branch sees pre-edge values.
            sram_en   <= 1'b0;
            inst_done <= 1'b0;
            data_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req || inst_req) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        sram_en <= 1'b1;
                        if (grant_data) begin
                            owner      <= OWN_DATA;
                            sram_we    <= data_we;
                            sram_addr  <= data_addr;
                            sram_wdata <= data_wdata;
                            if (!inst_req) begin
                                streak <= '0;
                            end else if (streak != STREAK_W'(MAX_STREAK)) begin
                                streak <= streak + STREAK_W'(1);
                            end
                        end else begin
                            owner      <= OWN_INST;
                            sram_we    <= inst_we;
                            sram_addr  <= inst_addr;
                            sram_wdata <= inst_wdata;
                            streak     <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= CNT_W'(SRAM_LAT - 1);
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= RESP;
                        if (owner == OWN_DATA) begin
                            data_rdata <= sram_rdata;
                            data_done  <= 1'b1;
                        end else begin
                            inst_rdata <= sram_rdata;
                            inst_done  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a SRAM_LAT=1 instance and a SRAM_LAT=3 instance,
// each backed by a behavioural synchronous SRAM model with matching read latency.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // SRAM_LAT=1 instance
    logic        inst_req, inst_we, inst_done, data_req, data_we, data_done;
    logic [31:0] inst_addr, inst_wdata, inst_rdata, data_addr, data_wdata, data_rdata;
    logic        sram_en, sram_we, busy;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    // SRAM_LAT=3 instance
    logic        l3_inst_req, l3_inst_we, l3_inst_done, l3_data_req, l3_data_we, l3_data_done;
    logic [31:0] l3_inst_addr, l3_inst_wdata, l3_inst_rdata, l3_data_addr, l3_data_wdata, l3_data_rdata;
    logic        l3_sram_en, l3_sram_we, l3_busy;
    logic [31:0] l3_sram_addr, l3_sram_wdata, l3_sram_rdata;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(1), .MAX_STREAK(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_done(inst_done), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_done(data_done), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .busy(busy)
    );

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(3), .MAX_STREAK(4)) dut3 (
        .clk(clk), .resetn(resetn),
        .inst_req(l3_inst_req), .inst_we(l3_inst_we), .inst_addr(l3_inst_addr), .inst_wdata(l3_inst_wdata),
        .inst_done(l3_inst_done), .inst_rdata(l3_inst_rdata),
        .data_req(l3_data_req), .data_we(l3_data_we), .data_addr(l3_data_addr), .data_wdata(l3_data_wdata),
        .data_done(l3_data_done), .data_rdata(l3_data_rdata),
        .sram_en(l3_sram_en), .sram_we(l3_sram_we), .sram_addr(l3_sram_addr), .sram_wdata(l3_sram_wdata),
        .sram_rdata(l3_sram_rdata), .busy(l3_busy)
    );

    // Behavioural SRAMs, word-indexed by addr[9:2]; the backdoor preloads both.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] pipe3 [3];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem1[bd_idx] <= bd_data;
        if (sram_en && sram_we) mem1[sram_addr[9:2]] <= sram_wdata;
        sram_rdata <= (sram_en && !sram_we) ? mem1[sram_addr[9:2]] : 32'hbad0_bad0;
    end

    always @(posedge clk) begin
        if (bd_we) mem3[bd_idx] <= bd_data;
        if (l3_sram_en && l3_sram_we) mem3[l3_sram_addr[9:2]] <= l3_sram_wdata;
        pipe3[0] <= (l3_sram_en && !l3_sram_we) ? mem3[l3_sram_addr[9:2]] : 32'hbad0_bad0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign l3_sram_rdata = pipe3[2];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_idx  = a[9:2];
        bd_data = d;
        cyc();
        bd_we   = 1'b0;
    endtask

    // Drives one request on the SRAM_LAT=1 instance and reports what was observed.
    task automatic do_access(input bit is_data, input logic we, input logic [31:0] a, input logic [31:0] wd,
                             output int en_cyc, output int en_cnt, output int done_cyc,
                             output logic [31:0] rd, output bit bus_ok, output bit other_done);
        en_cyc = -1; en_cnt = 0; done_cyc = -1; rd = '0; bus_ok = 1'b0; other_done = 1'b0;
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd;
        end else begin
            inst_req = 1'b1; inst_we = we; inst_addr = a; inst_wdata = wd;
        end
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (sram_en) begin
                en_cnt++;
                en_cyc = c;
                bus_ok = (sram_we === we) && (sram_addr === a) && (!we || (sram_wdata === wd));
            end
            if (is_data ? inst_done : data_done) other_done = 1'b1;
            if (is_data ? data_done : inst_done) begin
                done_cyc = c;
                rd = is_data ? data_rdata : inst_rdata;
                break;
            end
        end
        if (is_data) data_req = 1'b0;
        else         inst_req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({sram_en, sram_we, inst_done, data_done, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {sram_en, sram_we, inst_done, data_done, busy});
        end
        checks++;
        if ({sram_addr, sram_wdata, inst_rdata, data_rdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h exp=0", {sram_addr, sram_wdata, inst_rdata, data_rdata});
        end
        checks++;
        if ({l3_sram_en, l3_busy, l3_data_done, l3_inst_done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_lat3 got=%b exp=0000", {l3_sram_en, l3_busy, l3_data_done, l3_inst_done});
        end
        #2 resetn = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({busy, sram_en} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=00", {busy, sram_en});
        end
    endtask

    task automatic test_single_load();
        int en_cyc, en_cnt, done_cyc;
        logic [31:0] rd;
        bit bus_ok, other;
        preload(32'h1c00_0010, 32'hdead_beef);
        do_access(1'b1, 1'b0, 32'h1c00_0010, 32'h0, en_cyc, en_cnt, done_cyc, rd, bus_ok, other);
        checks++;
        if (en_cyc !== 1 || en_cnt !== 1) begin
            failures++;
            $display("FAIL load_sram_en cyc=%0d cnt=%0d exp cyc=1 cnt=1", en_cyc, en_cnt);
        end
        checks++;
        if (bus_ok !== 1'b1) begin
            failures++;
            $display("FAIL load_sram_cmd got=%b exp=1", bus_ok);
        end
        checks++;
        if (done_cyc !== 3) begin
            failures++;
            $display("FAIL load_latency got=%0d exp=3", done_cyc);
        end
        checks++;
        if (rd !== 32'hdead_beef || other !== 1'b0) begin
            failures++;
            $display("FAIL load_rdata got=%h inst_done_seen=%b exp=deadbeef 0", rd, other);
        end
        cyc();
        checks++;
        if ({data_done, busy, sram_en} !== 3'b000) begin
            failures++;
            $display("FAIL load_back_to_idle got=%b exp=000", {data_done, busy, sram_en});
        end
    endtask

    task automatic test_store_readback();
        int en_cyc, en_cnt, done_cyc;
        logic [31:0] rd;
        bit bus_ok, other;
        do_access(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, en_cyc, en_cnt, done_cyc, rd, bus_ok, other);
        checks++;
        if (en_cyc !== 1 || en_cnt !== 1 || bus_ok !== 1'b1) begin
            failures++;
            $display("FAIL store_cmd cyc=%0d cnt=%0d ok=%b exp 1 1 1", en_cyc, en_cnt, bus_ok);
        end
        checks++;
        if (done_cyc !== 3) begin
            failures++;
            $display("FAIL store_latency got=%0d exp=3", done_cyc);
        end
        // Request raised during RESP: must wait one extra cycle for IDLE.
        do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, en_cyc, en_cnt, done_cyc, rd, bus_ok, other);
        checks++;
        if (en_cyc !== 2 || done_cyc !== 4) begin
            failures++;
            $display("FAIL req_in_resp en=%0d done=%0d exp en=2 done=4", en_cyc, done_cyc);
        end
        checks++;
        if (rd !== 32'h1234_5678) begin
            failures++;
            $display("FAIL store_readback got=%h exp=12345678", rd);
        end
        cyc();
    endtask

    task automatic test_priority();
        logic [9:0] order;
        int n, last, gap_min, gap_max, rd_errs;
        bit both;
        n = 0; last = -1; gap_min = 1000; gap_max = 0; rd_errs = 0; both = 1'b0; order = '0;
        preload(32'h0000_0200, 32'ha5a5_0200);
        preload(32'h1c00_0000, 32'h3c3c_0000);
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0200;
        inst_req = 1'b1; inst_we = 1'b0; inst_addr = 32'h1c00_0000;
        for (int c = 1; c <= 80; c++) begin
            cyc();
            if (data_done && inst_done) both = 1'b1;
            if (data_done || inst_done) begin
                order[n] = data_done;
                if (data_done && data_rdata !== 32'ha5a5_0200) rd_errs++;
                if (!data_done && inst_rdata !== 32'h3c3c_0000) rd_errs++;
                if (last >= 0) begin
                    if (c - last < gap_min) gap_min = c - last;
                    if (c - last > gap_max) gap_max = c - last;
                end
                last = c;
                n++;
                if (n == 10) break;
            end
        end
        data_req = 1'b0;
        inst_req = 1'b0;
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL prio_done_count got=%0d exp=10", n);
        end
        checks++;
        if (order !== 10'b01_1110_1111) begin
            failures++;
            $display("FAIL prio_order got=%b exp=0111101111 (bit0 first, 1=data)", order);
        end
        checks++;
        if (both !== 1'b0 || rd_errs !== 0) begin
            failures++;
            $display("FAIL prio_done_overlap both=%b rd_errs=%0d exp 0 0", both, rd_errs);
        end
        checks++;
        if (gap_min !== 4 || gap_max !== 4) begin
            failures++;
            $display("FAIL prio_issue_spacing min=%0d max=%0d exp 4 4", gap_min, gap_max);
        end
        cyc();
    endtask

    task automatic test_fetch_stream();
        int k, first, last, gap_bad, rd_errs;
        bit dd;
        k = 0; first = -1; last = -1; gap_bad = 0; rd_errs = 0; dd = 1'b0;
        for (int i = 0; i < 4; i++) preload(32'h1c00_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        inst_req = 1'b1; inst_we = 1'b0; inst_addr = 32'h1c00_0000;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (data_done) dd = 1'b1;
            if (inst_done) begin
                if (first < 0) first = c;
                if (last >= 0 && c - last != 4) gap_bad++;
                last = c;
                if (inst_rdata !== 32'h1000_0000 + 32'(k)) rd_errs++;
                k++;
                inst_addr = inst_addr + 32'd4;
                if (k == 4) break;
            end
        end
        inst_req = 1'b0;
        checks++;
        if (k !== 4 || first !== 3) begin
            failures++;
            $display("FAIL fetch_count count=%0d first=%0d exp 4 3", k, first);
        end
        checks++;
        if (gap_bad !== 0) begin
            failures++;
            $display("FAIL fetch_spacing bad_gaps=%0d exp=0", gap_bad);
        end
        checks++;
        if (rd_errs !== 0 || dd !== 1'b0) begin
            failures++;
            $display("FAIL fetch_rdata errs=%0d data_done_seen=%b exp 0 0", rd_errs, dd);
        end
        cyc();
    endtask

    task automatic test_reset_mid_access();
        int n;
        bit stray;
        logic [4:0] order;
        n = 0; stray = 1'b0; order = '0;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0200;
        inst_req = 1'b1; inst_we = 1'b0; inst_addr = 32'h1c00_0000;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (data_done) n++;
            if (n == 2) break;
        end
        cyc();
        cyc();
        checks++;
        if (sram_en !== 1'b1 || sram_addr !== 32'h0000_0200) begin
            failures++;
            $display("FAIL abort_issue en=%b addr=%h exp 1 00000200", sram_en, sram_addr);
        end
        cyc();
        checks++;
        if (busy !== 1'b1 || sram_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_wait busy=%b en=%b exp 1 0", busy, sram_en);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({sram_en, busy, data_done, inst_done} !== 4'b0 || sram_addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset ctrl=%b addr=%h exp 0000 0",
                     {sram_en, busy, data_done, inst_done}, sram_addr);
        end
        data_req = 1'b0;
        inst_req = 1'b0;
        cyc();
        cyc();
        #3 resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (data_done || inst_done || sram_en || busy) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            failures++;
            $display("FAIL aborted_access_activity got=%b exp=0", stray);
        end
        // A cleared streak allows the full run of four data grants before fetch wins.
        n = 0;
        data_req = 1'b1;
        inst_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (data_done || inst_done) begin
                order[n] = data_done;
                n++;
                if (n == 5) break;
            end
        end
        data_req = 1'b0;
        inst_req = 1'b0;
        checks++;
        if (n !== 5 || order !== 5'b01111) begin
            failures++;
            $display("FAIL streak_after_reset n=%0d order=%b exp 5 01111", n, order);
        end
        cyc();
    endtask

    task automatic test_lat3();
        int en_cyc, en_cnt, done_cyc;
        logic [31:0] rd;
        bit other, busy_mid;
        en_cyc = -1; en_cnt = 0; done_cyc = -1; rd = '0; other = 1'b0; busy_mid = 1'b0;
        preload(32'h0000_0300, 32'hcafe_f00d);
        l3_data_req = 1'b1; l3_data_we = 1'b0; l3_data_addr = 32'h0000_0300;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (l3_sram_en) begin en_cnt++; en_cyc = c; end
            if (c == 4) busy_mid = l3_busy;
            if (l3_inst_done) other = 1'b1;
            if (l3_data_done) begin done_cyc = c; rd = l3_data_rdata; break; end
        end
        l3_data_req = 1'b0;
        checks++;
        if (en_cyc !== 1 || en_cnt !== 1) begin
            failures++;
            $display("FAIL lat3_sram_en cyc=%0d cnt=%0d exp 1 1", en_cyc, en_cnt);
        end
        checks++;
        if (done_cyc !== 5 || busy_mid !== 1'b1) begin
            failures++;
            $display("FAIL lat3_latency done=%0d busy_mid=%b exp 5 1", done_cyc, busy_mid);
        end
        checks++;
        if (rd !== 32'hcafe_f00d || other !== 1'b0) begin
            failures++;
            $display("FAIL lat3_rdata got=%h inst_done_seen=%b exp cafef00d 0", rd, other);
        end
        cyc();
    endtask

    initial begin
        inst_req = 1'b0; inst_we = 1'b0; inst_addr = '0; inst_wdata = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        l3_inst_req = 1'b0; l3_inst_we = 1'b0; l3_inst_addr = '0; l3_inst_wdata = '0;
        l3_data_req = 1'b0; l3_data_we = 1'b0; l3_data_addr = '0; l3_data_wdata = '0;
        test_reset();
        test_single_load();
        test_store_readback();
        test_priority();
        test_fetch_stream();
        test_reset_mid_access();
        test_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
